sar_conv_ctrl: RTL

//  Synthesizable SAR conversion sequencer; drives ready/register_clk into sar_clk_gen and consumes its clk_sample.
//  On the falling edge of clk_sample it runs NUM_BITS MSB-first compare cycles.

---
 rtl/sar_conv_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/sar_conv_ctrl.sv
// SAR sequencer: on a clk_sample fall, resolves NUM_BITS MSB-first over NUM_BITS*BIT_CYCLES cycles, then a 1-cycle DONE.
// Result latency fall-edge + NUM_BITS*BIT_CYCLES + 1; no backpressure, sample edges during a conversion only raise overrun.
module sar_conv_ctrl #(
    parameter int NUM_BITS   = 8,
    parameter int BIT_CYCLES = 4
) (
    input  logic                clk_1GHz,
    input  logic                reset_n,
    input  logic                clk_sample,
    input  logic                comp_out,
    output logic                ready,
    output logic                register_clk,
    output logic [NUM_BITS-1:0] dac_code,
    output logic [NUM_BITS-1:0] dout,
    output logic                dout_valid,
    output logic                busy,
    output logic                overrun
);

    localparam int BW = $clog2(NUM_BITS);
    localparam int PW = $clog2(BIT_CYCLES);
    localparam logic [BW-1:0] BIT_TOP = BW'(NUM_BITS - 1);
    localparam logic [PW-1:0] PH_LAST = PW'(BIT_CYCLES - 1);
    localparam logic [PW-1:0] PH_HALF = PW'(BIT_CYCLES / 2);
    localparam logic [NUM_BITS-1:0] MIDSCALE = {1'b1, {(NUM_BITS-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;

    state_t              state, nxt_state;
    logic                clk_sample_q;
    logic [BW-1:0]       bit_idx, nxt_bit_idx;
    logic [PW-1:0]       phase, nxt_phase;
    logic [NUM_BITS-1:0] resolved, nxt_resolved;
    logic [NUM_BITS-1:0] nxt_dac;
    logic [NUM_BITS-1:0] trial_bit;
    logic                fall, rise;

    assign fall = clk_sample_q & ~clk_sample;
    assign rise = ~clk_sample_q & clk_sample;

    always_ff @(posedge clk_1GHz or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            clk_sample_q <= 1'b0;
            bit_idx      <= BIT_TOP;
            phase        <= '0;
            resolved     <= '0;
            dac_code     <= '0;
            dout         <= '0;
            overrun      <= 1'b0;
        end else begin
            state        <= nxt_state;
            clk_sample_q <= clk_sample;
            bit_idx      <= nxt_bit_idx;
            phase        <= nxt_phase;
            resolved     <= nxt_resolved;
            dac_code     <= nxt_dac;
            overrun      <= (state != IDLE) && (rise || fall);
            // Capture on entry to DONE so dout is already new while dout_valid is high.
            if (state == COMPARE && nxt_state == DONE) begin
                dout <= nxt_resolved;
            end
        end
    end

    always_comb begin
        nxt_state    = state;
        nxt_bit_idx  = bit_idx;
        nxt_phase    = phase;
        nxt_resolved = resolved;
        case (state)
            IDLE: begin
                if (fall) begin
                    nxt_state    = COMPARE;
                    nxt_bit_idx  = BIT_TOP;
                    nxt_phase    = '0;
                    nxt_resolved = '0;
                end
            end
            COMPARE: begin
                if (phase == PH_LAST) begin
                    nxt_phase             = '0;
                    nxt_resolved[bit_idx] = comp_out;
                    if (bit_idx == '0) begin
                        nxt_state = DONE;
                    end else begin
                        nxt_bit_idx = bit_idx - 1'b1;
                    end
                end else begin
                    nxt_phase = phase + 1'b1;
                end
            end
            DONE:    nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    // dac_code is registered from next-state values so it reads 0 in reset yet tracks the state with no lag.
    always_comb begin
        trial_bit              = '0;
        trial_bit[nxt_bit_idx] = 1'b1;
        case (nxt_state)
            COMPARE: nxt_dac = nxt_resolved | trial_bit;
            DONE:    nxt_dac = nxt_resolved;
            default: nxt_dac = MIDSCALE;
        endcase
    end

    always_comb begin
        ready        = 1'b1;
        register_clk = 1'b0;
        busy         = 1'b0;
        dout_valid   = 1'b0;
        case (state)
            IDLE:    register_clk = ~clk_sample_q;
            COMPARE: begin
                busy  = 1'b1;
                ready = (phase >= PH_HALF);
            end
            DONE: begin
                busy       = 1'b1;
                dout_valid = 1'b1;
            end
            default: ready = 1'b1;
        endcase
    end

endmodule
